// File: rtl/write_req_pkg.sv
// Shared types and helpers for the write request arbiter.
package write_req_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } write_req_t;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/write_req_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
// Zero latency; no backpressure of its own.
module write_req_rr_pick
    import write_req_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_valid
);

    int               pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_valid  = 1'b0;
        pos        = 0;
        cand       = '0;
        // ptr is always below NUM_REQ, so one subtraction wraps the search.
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!any_valid && req[cand]) begin
                any_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_onehot[gnt_idx] = any_valid;
    end

endmodule

// File: rtl/write_req_arbiter.sv
// Round-robin arbiter of NUM_REQ write requesters onto one registered channel; 1-cycle latency.
// Accepts only when the output is empty or draining; WRITE_REQ_ARB_BURST_EN enables burst hold.
module write_req_arbiter
    import write_req_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [ADDR_WIDTH-1:0]         out_address,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_grant_id,
    input  logic                          out_ready
);

    localparam int IDX_W = clog2_min1(NUM_REQ);

    logic                  out_valid_q,    out_valid_d;
    logic [ADDR_WIDTH-1:0] out_address_q,  out_address_d;
    logic [DATA_WIDTH-1:0] out_data_q,     out_data_d;
    logic [IDX_W-1:0]      out_grant_id_q, out_grant_id_d;
    logic [IDX_W-1:0]      ptr_q,          ptr_d;

    logic                  cap;
    logic                  hold;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;
    logic [ADDR_WIDTH-1:0] win_address;
    logic [DATA_WIDTH-1:0] win_data;
    logic [IDX_W-1:0]      win_idx_next;

    assign cap = !out_valid_q || out_ready;

    write_req_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any_valid  (pick_any)
    );

`ifdef WRITE_REQ_ARB_BURST_EN
    localparam int CNT_W = clog2_min1(MAX_BURST + 1);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    // The last winner is whoever sits in the output register.
    assign hold = (burst_cnt_q != '0) && (int'(burst_cnt_q) < MAX_BURST)
                  && req_valid[out_grant_id_q];

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (cap) begin
            if (win_any) begin
                burst_cnt_d = hold ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
            end else begin
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    logic unused_max_burst;

    assign hold             = 1'b0;
    assign unused_max_burst = (MAX_BURST < 1);
`endif

    always_comb begin
        win_onehot = pick_onehot;
        win_idx    = pick_idx;
        win_any    = pick_any;
        if (hold) begin
            win_onehot                 = '0;
            win_onehot[out_grant_id_q] = 1'b1;
            win_idx                    = out_grant_id_q;
            win_any                    = 1'b1;
        end
    end

    always_comb begin
        win_address = '0;
        win_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign win_idx_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    // Ready is masked during reset so nothing is accepted and then dropped.
    assign req_ready = (cap && !RST) ? win_onehot : '0;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_address_d  = out_address_q;
        out_data_d     = out_data_q;
        out_grant_id_d = out_grant_id_q;
        ptr_d          = ptr_q;
        if (cap) begin
            if (win_any) begin
                out_valid_d    = 1'b1;
                out_address_d  = win_address;
                out_data_d     = win_data;
                out_grant_id_d = win_idx;
                if (!hold) begin
                    ptr_d = win_idx_next;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q    <= 1'b0;
            out_address_q  <= '0;
            out_data_q     <= '0;
            out_grant_id_q <= '0;
            ptr_q          <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_address_q  <= out_address_d;
            out_data_q     <= out_data_d;
            out_grant_id_q <= out_grant_id_d;
            ptr_q          <= ptr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_address  = out_address_q;
    assign out_data     = out_data_q;
    assign out_grant_id = out_grant_id_q;

endmodule

// File: tb/tb_write_req_arbiter.sv
// Directed bench for write_req_arbiter with hand-computed expectations.
module tb_write_req_arbiter;

    logic         CLK;
    logic         RST;
    logic [3:0]   req_valid;
    logic [127:0] req_address;
    logic [31:0]  req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_address;
    logic [7:0]   out_data;
    logic [1:0]   out_grant_id;
    logic         out_ready;

    int n_checks;
    int n_fail;

    write_req_arbiter #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_address  (req_address),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_address  (out_address),
        .out_data     (out_data),
        .out_grant_id (out_grant_id),
        .out_ready    (out_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] a, input logic [7:0] d);
        req_address[i*32 +: 32] = a;
        req_data[i*8 +: 8]      = d;
    endtask

    task automatic fill_all_slots();
        for (int i = 0; i < 4; i++) begin
            set_slot(i, 32'h2000_0000 + 32'(i * 16), 8'hA0 + 8'(i));
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST         = 1'b1;
        req_valid   = 4'b1111;
        out_ready   = 1'b1;
        req_address = '0;
        req_data    = '0;
        fill_all_slots();
        tick();
        tick();
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (out_address !== 32'h0 || out_data !== 8'h0 || out_grant_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_regs: got %h/%h/%0d want 0/0/0", out_address, out_data, out_grant_id);
        end
        req_valid = 4'b0000;
        RST       = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_slot(2, 32'h1000_0040, 8'h5A);
        req_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        n_checks++;
        if (out_valid !== 1'b1 || out_grant_id !== 2'd2) begin
            n_fail++; $display("FAIL single_out: got vld=%b id=%0d want vld=1 id=2", out_valid, out_grant_id);
        end
        n_checks++;
        if (out_address !== 32'h1000_0040 || out_data !== 8'h5A) begin
            n_fail++; $display("FAIL single_payload: got %h/%h want 10000040/5a", out_address, out_data);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got %b want 0", out_valid);
        end
        fill_all_slots();
    endtask

    // Pointer is 3 after the single-requester test (winner 2).
    task automatic test_wrap();
        req_valid = 4'b0011;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_ready0: got %b want 0001", req_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_grant_id !== 2'd0 || out_address !== 32'h2000_0000) begin
            n_fail++; $display("FAIL wrap_grant0: got vld=%b id=%0d addr=%h want 1/0/20000000", out_valid, out_grant_id, out_address);
        end
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL wrap_ready1: got %b want 0010", req_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_grant_id !== 2'd1 || out_data !== 8'hA1) begin
            n_fail++; $display("FAIL wrap_grant1: got vld=%b id=%0d data=%h want 1/1/a1", out_valid, out_grant_id, out_data);
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_all_valid();
        logic [1:0] exp_id;
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_id = 2'(k % 4);
            n_checks++;
            if (out_valid !== 1'b1 || out_grant_id !== exp_id) begin
                n_fail++; $display("FAIL rr_seq[%0d]: got vld=%b id=%0d want 1/%0d", k, out_valid, out_grant_id, exp_id);
            end
            n_checks++;
            if (out_address !== 32'h2000_0000 + 32'(exp_id) * 16) begin
                n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", k, out_address, 32'h2000_0000 + 32'(exp_id) * 16);
            end
        end
        req_valid = 4'b0000;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_drain: got %b want 0", out_valid);
        end
    endtask

    // Pointer is 0 after the fairness test (last winner 3).
    task automatic test_backpressure();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_grant_id !== 2'd0 || out_address !== 32'h2000_0000 || out_data !== 8'hA0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %b/%0d/%h/%h want 1/0/20000000/a0", k, out_valid, out_grant_id, out_address, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_resume_ready: got %b want 0010", req_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_grant_id !== 2'd1) begin
            n_fail++; $display("FAIL bp_resume: got vld=%b id=%0d want 1/1", out_valid, out_grant_id);
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1000;
        out_ready = 1'b0;
        tick();
        req_valid = 4'b0000;
        n_checks++;
        if (out_valid !== 1'b1 || out_grant_id !== 2'd3) begin
            n_fail++; $display("FAIL rstmid_setup: got vld=%b id=%0d want 1/3", out_valid, out_grant_id);
        end
        #2;
        RST       = 1'b1;
        req_valid = 4'b0110;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_grant_id !== 2'd0 || out_address !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_async: got vld=%b id=%0d addr=%h want 0/0/0", out_valid, out_grant_id, out_address);
        end
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 0000", req_ready);
        end
        tick();
        RST       = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL rstmid_first_ready: got %b want 0010", req_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_grant_id !== 2'd1) begin
            n_fail++; $display("FAIL rstmid_first: got vld=%b id=%0d want 1/1", out_valid, out_grant_id);
        end
        req_valid = 4'b0000;
        tick();
    endtask

`ifdef WRITE_REQ_ARB_BURST_EN
    task automatic test_burst();
        logic [1:0] exp_ids [6];
        exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_grant_id !== exp_ids[k]) begin
                n_fail++; $display("FAIL burst_seq[%0d]: got vld=%b id=%0d want 1/%0d", k, out_valid, out_grant_id, exp_ids[k]);
            end
        end
        req_valid = 4'b1101;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL burst_drop_ready: got %b want 0100", req_ready);
        end
        tick();
        n_checks++;
        if (out_grant_id !== 2'd2) begin
            n_fail++; $display("FAIL burst_drop: got id=%0d want 2", out_grant_id);
        end
        req_valid = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_wrap();
`ifdef WRITE_REQ_ARB_BURST_EN
        test_reset_mid();
        test_burst();
`else
        test_all_valid();
        test_backpressure();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_req_arbiter.md
# write_req_arbiter

Round-robin arbiter that shares one WriteReq-style write channel (address, data, valid) among NUM_REQ requesters. Each requester presents a write request with a valid/ready handshake. The arbiter captures one winner per cycle into a single output register and drives the shared downstream channel, which applies backpressure through out_ready. It sits between several write masters and the single WriteReq consumer at the top level.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- ADDR_WIDTH, 32: write address width.
- DATA_WIDTH, 8: write data width.
- MAX_BURST, 4: maximum consecutive grants to one requester. Used only when burst mode is compiled in. Must be ≥1.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_address  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies slice i.
- req_ready  out  NUM_REQ  one-hot-or-zero; request i is accepted when req_valid[i] & req_ready[i].
- out_valid  out  1  shared channel valid.
- out_address  out  ADDR_WIDTH  shared channel address.
- out_data  out  DATA_WIDTH  shared channel data.
- out_grant_id  out  $clog2(NUM_REQ)  index of the requester whose write is currently on the output.
- out_ready  in  1  downstream accepts the output when out_valid & out_ready.

## Operation
- Capture condition: cap = !out_valid | out_ready. The output register is empty or is draining this cycle.
- When cap is high and any req_valid is high:
  - Pick the winner g by round-robin. Search starts at index ptr and wraps modulo NUM_REQ.
  - Assert req_ready[g] combinationally in the same cycle.
  - On the edge: load out_address, out_data and out_grant_id from slice g; set out_valid=1; set ptr = (g+1) mod NUM_REQ.
- When cap is high and no request is valid: out_valid clears on the edge; ptr is unchanged.
- When cap is low: req_ready=0, and all output registers and ptr hold.
- req_ready never depends on out_valid alone. It depends on cap and req_valid only.
- Output stability: once out_valid=1, out_address, out_data and out_grant_id stay constant until the cycle the output is accepted.
- Requesters must hold valid, address and data until accepted. The arbiter does not check this.
- No state machine beyond the output register, ptr, and (optionally) the burst counter.

## Timing
- Latency: a request accepted at edge N appears on out_valid from cycle N+1.
- Throughput: one write per cycle when out_ready is held high.
- Back-to-back: accept and new capture in the same cycle gives continuous out_valid with no bubble.
- Simultaneous requests: exactly one req_ready high per cycle, chosen by ptr order.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,… (burst mode off).
- Reset values: out_valid=0, out_address=0, out_data=0, out_grant_id=0, ptr=0, burst count=0. req_ready=0 while RST is high.
- Reset mid-transfer: any pending output is dropped immediately (asynchronous); no replay.

## Configuration
- Macro: WRITE_REQ_ARB_BURST_EN.
- Defined: a burst counter holds the grant on the last winner L while req_valid[L]=1 and the count is below MAX_BURST, instead of rotating.
  - ptr advances to L+1 only when the burst ends. A burst ends when MAX_BURST grants have been made or req_valid[L] drops.
  - The count resets to 1 on each new winner.
- Undefined: pure round-robin as described above; the counter logic is absent.

## Structure
- Package write_req_pkg:
  - write_req_t struct (address, data) parameterised through package localparams ADDR_W=32, DATA_W=8.
  - Function clog2_min1, with a minimum result of 1.
- Sub-module write_req_rr_pick:
  - Combinational round-robin picker.
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, grant index, any_valid.
  - Instantiated once.

## Test plan
- Single requester:
  - Stimulus: req_valid=4'b0100, address 0x1000_0040, data 0x5A, out_ready=1.
  - Response: req_ready=4'b0100 the same cycle; next cycle out_valid=1, out_address=0x1000_0040, out_data=0x5A, out_grant_id=2.
- All valid, burst off:
  - Stimulus: req_valid=4'b1111 for 8 cycles, out_ready=1.
  - Response: out_grant_id sequence 0,1,2,3,0,1,2,3; out_valid continuous.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while out_valid=1.
  - Response: outputs stable, req_ready=0; after out_ready rises, the next grant goes to ptr order.
- Wrap-around:
  - Stimulus: ptr=3, req_valid=4'b0011.
  - Response: grant 0, then grant 1.
- Reset mid-operation:
  - Stimulus: RST asserted while out_valid=1.
  - Response: out_valid=0 immediately, without waiting for a clock edge; after release, the first grant goes to the lowest valid index starting from 0.
- Burst mode (WRITE_REQ_ARB_BURST_EN, MAX_BURST=4):
  - Stimulus: all requesters valid.
  - Response: grant ids 0,0,0,0,1,1,1,1; if req_valid[1] drops after 2 grants, the next grant goes to 2.
